// File: rtl/ysyx_22040632_mul_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package ysyx_22040632_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int MUL_STEPS_U = 33;  // unsigned multiplier: one extra triplet covers y[63]
  localparam int MUL_STEPS_S = 32;  // signed 64-bit multiplier
  localparam int MUL_STEPS_W = 16;  // 32-bit word multiply
  localparam int ACC_W       = 128;

  // Number of Booth steps for an operation.
  function automatic logic [5:0] mul_steps(input logic is_word, input logic y_signed);
    logic [5:0] steps_v;
    if (is_word) begin
      steps_v = 6'(MUL_STEPS_W);
    end else if (y_signed) begin
      steps_v = 6'(MUL_STEPS_S);
    end else begin
      steps_v = 6'(MUL_STEPS_U);
    end
    return steps_v;
  endfunction

endpackage

// File: rtl/ysyx_22040632_booth.sv
// One radix-4 Booth step: selects 0/+-x/+-2x from a y triplet and places it
// at weight 4^index. A negative multiple is returned as the shifted one's
// complement in p plus the matching +1 (at the same weight) in c, so that
// p + c equals the two's-complement partial product modulo 2^128.
module ysyx_22040632_booth
  import ysyx_22040632_mul_pkg::*;
(
  input  logic [ACC_W-1:0] in_x,
  input  logic [2:0]       in_y,
  input  logic [4:0]       index,
  output logic [ACC_W-1:0] p,
  output logic [ACC_W-1:0] c
);

  logic [ACC_W-1:0] mag_s;
  logic             neg_s;
  logic [5:0]       shamt_s;

  assign shamt_s = {index, 1'b0};

  // Decode the triplet into a multiple of x and its sign, then weight it.
  always_comb begin
    mag_s = '0;
    neg_s = 1'b0;
    case (in_y)
      3'b001, 3'b010: begin
        mag_s = in_x;
        neg_s = 1'b0;
      end
      3'b011: begin
        mag_s = {in_x[ACC_W-2:0], 1'b0};
        neg_s = 1'b0;
      end
      3'b100: begin
        mag_s = {in_x[ACC_W-2:0], 1'b0};
        neg_s = 1'b1;
      end
      3'b101, 3'b110: begin
        mag_s = in_x;
        neg_s = 1'b1;
      end
      default: begin
        mag_s = '0;
        neg_s = 1'b0;
      end
    endcase
    if (neg_s) begin
      p = (~mag_s) << shamt_s;
      c = {{(ACC_W-1){1'b0}}, 1'b1} << shamt_s;
    end else begin
      p = mag_s << shamt_s;
      c = '0;
    end
  end

endmodule

// File: rtl/ysyx_22040632_mul_seq.sv
// Iterative radix-4 Booth multiplier for RV64M mul/mulh/mulhsu/mulhu/mulw.
// One Booth step per BUSY cycle, 128-bit accumulator, valid/ready result.
// Optional macro YSYX_22040632_MUL_EARLY_EXIT_EN: finish as soon as every
// remaining multiplier triplet is 000/111 (same result, shorter latency).
module ysyx_22040632_mul_seq
  import ysyx_22040632_mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic            flush,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  mul_state_e       state_r, state_nxt_s;
  logic [5:0]       cnt_r, cnt_nxt_s, steps_r, steps_s;
  logic [ACC_W-1:0] acc_r, acc_nxt_s, acc_sum_s;
  logic [ACC_W-1:0] x_r, x_ext_s, booth_x_s, booth_p_s, booth_c_s;
  logic [65:0]      y_r, y_ext_s;
  logic             mulw_r;
  logic             out_valid_r, ready_r;
  logic [XLEN-1:0]  res_hi_r, res_lo_r;
  logic             accept_s, res_load_s, last_step_s;
  logic [63:0]      x_src_s, y_src_s;
  logic             x_sgn_s, y_sgn_s;
  logic [66:0]      yb_s, yb_sh_s;
  logic [6:0]       sh_s;
  logic [2:0]       booth_y_s;
  logic [4:0]       booth_idx_s;

  // Operand extension for the request currently presented.
  always_comb begin
    if (mulw) begin
      x_src_s = {{32{multiplicand[31]}}, multiplicand[31:0]};
      y_src_s = {{32{multiplier[31]}}, multiplier[31:0]};
      x_sgn_s = 1'b1;
      y_sgn_s = 1'b1;
    end else begin
      x_src_s = multiplicand;
      y_src_s = multiplier;
      x_sgn_s = mul_signed[1];
      y_sgn_s = mul_signed[0];
    end
    x_ext_s = {{64{x_sgn_s & x_src_s[63]}}, x_src_s};
    y_ext_s = {{2{y_sgn_s & y_src_s[63]}}, y_src_s};
    steps_s = mul_steps(mulw, y_sgn_s);
  end

  // y with the implicit y[-1]=0 appended: yb_s[i] holds y_ext[i-1].
  assign yb_s    = {y_r, 1'b0};
  assign sh_s    = {cnt_r, 1'b0};
  assign yb_sh_s = yb_s >> sh_s;

  // Booth step selection; the 33rd step reuses index 31 with x pre-shifted.
  always_comb begin
    booth_y_s = yb_sh_s[2:0];
    if (cnt_r == 6'd32) begin
      booth_x_s   = {x_r[ACC_W-3:0], 2'b00};
      booth_idx_s = 5'd31;
    end else begin
      booth_x_s   = x_r;
      booth_idx_s = cnt_r[4:0];
    end
  end

  ysyx_22040632_booth u_booth (
    .in_x  (booth_x_s),
    .in_y  (booth_y_s),
    .index (booth_idx_s),
    .p     (booth_p_s),
    .c     (booth_c_s)
  );

  assign acc_sum_s   = acc_r + booth_p_s + booth_c_s;
  assign last_step_s = (cnt_r == (steps_r - 6'd1));

`ifdef YSYX_22040632_MUL_EARLY_EXIT_EN
  localparam logic [66:0] YB_ONES = '1;
  logic [66:0] yb_nx_s;
  logic        rem_same_s, nxt_same_s;

  // Remaining-triplet test for this step and for the following step.
  always_comb begin
    yb_nx_s    = yb_s >> (sh_s + 7'd2);
    rem_same_s = (yb_sh_s == 67'd0) || (yb_sh_s == (YB_ONES >> sh_s));
    nxt_same_s = (yb_nx_s == 67'd0) || (yb_nx_s == (YB_ONES >> (sh_s + 7'd2)));
  end
`endif

  // Next-state, counter and accumulator logic; flush overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    acc_nxt_s   = acc_r;
    accept_s    = 1'b0;
    res_load_s  = 1'b0;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (mul_valid) begin
            accept_s    = 1'b1;
            state_nxt_s = BUSY;
            cnt_nxt_s   = 6'd0;
            acc_nxt_s   = '0;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        BUSY: begin
`ifdef YSYX_22040632_MUL_EARLY_EXIT_EN
          if (rem_same_s) begin
            state_nxt_s = DONE;
            res_load_s  = 1'b1;
          end else begin
            acc_nxt_s = acc_sum_s;
            cnt_nxt_s = cnt_r + 6'd1;
            if (last_step_s || nxt_same_s) begin
              state_nxt_s = DONE;
              res_load_s  = 1'b1;
            end else begin
              state_nxt_s = BUSY;
            end
          end
`else
          acc_nxt_s = acc_sum_s;
          cnt_nxt_s = cnt_r + 6'd1;
          if (last_step_s) begin
            state_nxt_s = DONE;
            res_load_s  = 1'b1;
          end else begin
            state_nxt_s = BUSY;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered output updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 6'd0;
      acc_r       <= '0;
      x_r         <= '0;
      y_r         <= '0;
      steps_r     <= 6'd0;
      mulw_r      <= 1'b0;
      out_valid_r <= 1'b0;
      ready_r     <= 1'b1;
      res_hi_r    <= '0;
      res_lo_r    <= '0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      acc_r       <= acc_nxt_s;
      out_valid_r <= (state_nxt_s == DONE);
      ready_r     <= (state_nxt_s == IDLE);
      if (accept_s) begin
        x_r     <= x_ext_s;
        y_r     <= y_ext_s;
        steps_r <= steps_s;
        mulw_r  <= mulw;
      end
      if (res_load_s) begin
        res_hi_r <= acc_nxt_s[127:64];
        if (mulw_r) begin
          res_lo_r <= {{32{acc_nxt_s[31]}}, acc_nxt_s[31:0]};
        end else begin
          res_lo_r <= acc_nxt_s[63:0];
        end
      end
    end
  end

  assign mul_ready = ready_r;
  assign out_valid = out_valid_r;
  assign result_hi = res_hi_r;
  assign result_lo = res_lo_r;

endmodule

// File: tb/tb_ysyx_22040632_mul_seq.sv
// Self-checking bench for ysyx_22040632_mul_seq: directed vector table,
// flush/reset/backpressure sequences and randomized operations checked
// against a plain 128-bit arithmetic reference.
module tb_ysyx_22040632_mul_seq;

  logic        clk, rst_n, mul_valid, mul_ready, flush, mulw;
  logic [1:0]  mul_signed;
  logic [63:0] multiplicand, multiplier, result_hi, result_lo;
  logic        out_valid, out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  ysyx_22040632_mul_seq #(.XLEN(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mul_valid    (mul_valid),
    .mul_ready    (mul_ready),
    .flush        (flush),
    .mulw         (mulw),
    .mul_signed   (mul_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_hi    (result_hi),
    .result_lo    (result_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a, b;
    logic [1:0]  sg;
    logic        w;
    logic [63:0] hi, lo;
    int          s;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
    end
  endtask

  // Reference: full-width product of the extended operands.
  function automatic void ref_mul(input logic [63:0] a, input logic [63:0] b,
                                  input logic [1:0] sg, input logic w,
                                  output logic [63:0] hi, output logic [63:0] lo,
                                  output int s);
    logic [127:0] xa, yb, pr;
    if (w) begin
      xa = {{96{a[31]}}, a[31:0]};
      yb = {{96{b[31]}}, b[31:0]};
    end else begin
      xa = sg[1] ? {{64{a[63]}}, a} : {64'd0, a};
      yb = sg[0] ? {{64{b[63]}}, b} : {64'd0, b};
    end
    pr = xa * yb;
    hi = pr[127:64];
    lo = w ? {{32{pr[31]}}, pr[31:0]} : pr[63:0];
    s  = w ? 16 : (sg[0] ? 32 : 33);
  endfunction

  task automatic do_mul(input string nm, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] sg, input logic w,
                        input logic [63:0] ehi, input logic [63:0] elo,
                        input int es, input int hold);
    int          edges;
    logic        rbad, sbad;
    logic [63:0] hi0, lo0;
    @(negedge clk);
    chk({nm, " ready_before"}, 64'(mul_ready), 64'd1);
    mul_valid = 1'b1; multiplicand = a; multiplier = b; mul_signed = sg; mulw = w;
    out_ready = 1'b0;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    rbad = 1'b0;
    while (!out_valid && edges < 200) begin
      if (mul_ready) rbad = 1'b1;
      // junk requests while busy must be ignored
      multiplicand = {$urandom, $urandom};
      multiplier   = {$urandom, $urandom};
      mul_signed   = 2'($urandom);
      mulw         = 1'($urandom);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    mul_valid = 1'b0;
    chk({nm, " latency"}, 64'(edges), 64'(es + 1));
    chk({nm, " ready_busy"}, 64'(rbad), 64'd0);
    chk({nm, " hi"}, result_hi, ehi);
    chk({nm, " lo"}, result_lo, elo);
    chk({nm, " ready_done"}, 64'(mul_ready), 64'd0);
    sbad = 1'b0; hi0 = result_hi; lo0 = result_lo;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || result_hi !== hi0 || result_lo !== lo0 || mul_ready) sbad = 1'b1;
    end
    if (hold > 0) chk({nm, " hold_stable"}, 64'(sbad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " valid_after"}, 64'(out_valid), 64'd0);
    chk({nm, " ready_after"}, 64'(mul_ready), 64'd1);
  endtask

  task automatic no_result(input string nm, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk({nm, " no_result"}, 64'(seen), 64'd0);
  endtask

  // Abort an op in cycle N+5 with flush or reset, then run a fresh multiply.
  task automatic abort_seq(input logic use_rst);
    string nm;
    nm = use_rst ? "reset_mid" : "flush_mid";
    @(negedge clk);
    mul_valid = 1'b1; multiplicand = 64'd3; multiplier = 64'd5;
    mul_signed = 2'b11; mulw = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mul_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    if (use_rst) rst_n = 1'b0;
    else flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; flush = 1'b0;
    chk({nm, " ready"}, 64'(mul_ready), 64'd1);
    chk({nm, " valid"}, 64'(out_valid), 64'd0);
    if (use_rst) begin
      chk({nm, " hi_zero"}, result_hi, 64'd0);
      chk({nm, " lo_zero"}, result_lo, 64'd0);
    end
    no_result(nm, 40);
    out_ready = 1'b0;
    do_mul({nm, " 7x6"}, 64'd7, 64'd6, 2'b11, 1'b0, 64'd0, 64'd42, 32, 0);
  endtask

  initial begin
    logic [63:0] ra, rb, rhi, rlo;
    logic [1:0]  rsg;
    logic        rw;
    int          rs, edges;

    vecs[0] = '{64'd3, 64'd5, 2'b11, 1'b0, 64'd0, 64'd15, 32};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 33};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 33};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0,
                64'd0, 64'd1, 32};
    vecs[4] = '{64'h1234_0000_7FFF_FFFF, 64'd2, 2'b00, 1'b1,
                64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 16};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 2'b11, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, 32};
    vecs[6] = '{64'd7, 64'd6, 2'b11, 1'b0, 64'd0, 64'd42, 32};

    rst_n = 1'b0; mul_valid = 1'b0; flush = 1'b0; mulw = 1'b0;
    mul_signed = 2'b00; multiplicand = 64'd0; multiplier = 64'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 64'(mul_ready), 64'd1);
    chk("reset valid", 64'(out_valid), 64'd0);
    chk("reset hi", result_hi, 64'd0);
    chk("reset lo", result_lo, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].w,
             vecs[i].hi, vecs[i].lo, vecs[i].s, (i == 1) ? 10 : 0);
    end

    abort_seq(1'b0);
    abort_seq(1'b1);

    // Request together with flush is not accepted.
    @(negedge clk);
    mul_valid = 1'b1; flush = 1'b1; multiplicand = 64'd7; multiplier = 64'd6;
    mul_signed = 2'b11; mulw = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mul_valid = 1'b0; flush = 1'b0;
    chk("valid_flush ready", 64'(mul_ready), 64'd1);
    no_result("valid_flush", 40);

    // Flush while a result is waiting in DONE.
    @(negedge clk);
    mul_valid = 1'b1; multiplicand = 64'd3; multiplier = 64'd5;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    mul_valid = 1'b0;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("done_flush reached", 64'(out_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("done_flush valid", 64'(out_valid), 64'd0);
    chk("done_flush ready", 64'(mul_ready), 64'd1);

    for (int i = 0; i < 40; i++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if ((i % 4) == 1) rb = 64'($urandom_range(0, 15));
      if ((i % 4) == 2) ra = -64'($urandom_range(0, 15));
      rsg = 2'($urandom_range(0, 3));
      rw  = ($urandom_range(0, 3) == 0);
      ref_mul(ra, rb, rsg, rw, rhi, rlo, rs);
      do_mul($sformatf("rand%0d", i), ra, rb, rsg, rw, rhi, rlo, rs,
             int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
